// File: rtl/sync_edge_filter.sv
// sync_edge_filter: per-channel flop synchroniser, optional persistence filter, edge detector and
// retriggerable pulse stretcher. Define SYNC_EDGE_FILT_FILTER_EN to enable the FILT_LEN glitch filter.
module sync_edge_filter #(
    parameter int WIDTH    = 4,
    parameter int STAGES   = 2,
    parameter int FILT_LEN = 4,
    parameter int STRETCH  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] stretch
);
    localparam int SCW = $clog2(STRETCH + 1);
    localparam logic [SCW-1:0] STRETCH_LD = SCW'(STRETCH);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_edge_filter: STAGES must be >= 2");
    end
    if (WIDTH < 1 || FILT_LEN < 1 || STRETCH < 1) begin : g_bad_params
        $error("sync_edge_filter: WIDTH, FILT_LEN and STRETCH must be >= 1");
    end

    logic [WIDTH-1:0] sync_r [STAGES];
    logic [WIDTH-1:0] sy_s;
    logic [WIDTH-1:0] lvl_nxt_s;
    logic [SCW-1:0]   scnt_r [WIDTH];
    logic [SCW-1:0]   scnt_nxt_s [WIDTH];
    logic [WIDTH-1:0] stretch_nxt_s;

    // synchroniser chain: din is only ever captured by sync_r[0]
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_r[i] <= '0;
            end
        end else begin
            sync_r[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign sy_s = sync_r[STAGES-1];

`ifdef SYNC_EDGE_FILT_FILTER_EN
    localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);

    logic [FCW-1:0] fcnt_r [WIDTH];
    logic [FCW-1:0] fcnt_nxt_s [WIDTH];

    // a differing synced value is accepted only after FILT_LEN consecutive cycles
    always_comb begin
        lvl_nxt_s = level;
        for (int i = 0; i < WIDTH; i++) begin
            fcnt_nxt_s[i] = '0;
            if (sy_s[i] == level[i]) begin
                fcnt_nxt_s[i] = '0;
            end else if (fcnt_r[i] == FILT_LAST) begin
                lvl_nxt_s[i]  = sy_s[i];
                fcnt_nxt_s[i] = '0;
            end else begin
                fcnt_nxt_s[i] = fcnt_r[i] + 1'b1;
            end
        end
    end

    // persistence counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                fcnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                fcnt_r[i] <= fcnt_nxt_s[i];
            end
        end
    end
`else
    // unfiltered: level follows the synchroniser output directly
    always_comb begin
        lvl_nxt_s = sy_s;
    end
`endif

    // stretch counter reloads on every rise, so back-to-back events never leave a gap
    always_comb begin
        stretch_nxt_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            scnt_nxt_s[i] = '0;
            if (lvl_nxt_s[i] && !level[i]) begin
                scnt_nxt_s[i] = STRETCH_LD;
            end else if (scnt_r[i] != '0) begin
                scnt_nxt_s[i] = scnt_r[i] - 1'b1;
            end else begin
                scnt_nxt_s[i] = '0;
            end
            stretch_nxt_s[i] = (scnt_nxt_s[i] != '0);
        end
    end

    // registered level, edge pulses and stretch state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level   <= '0;
            rise    <= '0;
            fall    <= '0;
            stretch <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                scnt_r[i] <= '0;
            end
        end else begin
            level   <= lvl_nxt_s;
            rise    <= lvl_nxt_s & ~level;
            fall    <= ~lvl_nxt_s & level;
            stretch <= stretch_nxt_s;
            for (int i = 0; i < WIDTH; i++) begin
                scnt_r[i] <= scnt_nxt_s[i];
            end
        end
    end

endmodule

// File: tb/tb_sync_edge_filter.sv
// Bench for sync_edge_filter: default instance (A) and an 8-channel, 3-stage, STRETCH=10 instance (B),
// checked by directed sequences, a steady-state table and randomized stimulus against a history-window model.
module tb_sync_edge_filter;
    localparam int NI = 2;
    localparam int WA = 4, SA = 2, FA = 4, TA = 3;
    localparam int WB = 8, SB = 3, FB = 4, TB = 10;
`ifdef SYNC_EDGE_FILT_FILTER_EN
    localparam int FEA = FA;
    localparam int FEB = FB;
`else
    localparam int FEA = 1;
    localparam int FEB = 1;
`endif
    localparam int LAT_A = SA + FEA - 1;
    localparam int LAT_B = SB + FEB - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [WA-1:0] din_a, level_a, rise_a, fall_a, stretch_a;
    logic [WB-1:0] din_b, level_b, rise_b, fall_b, stretch_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_edge_filter #(.WIDTH(WA), .STAGES(SA), .FILT_LEN(FA), .STRETCH(TA)) dut_a (
        .clk(clk), .rst(rst), .din(din_a),
        .level(level_a), .rise(rise_a), .fall(fall_a), .stretch(stretch_a)
    );

    sync_edge_filter #(.WIDTH(WB), .STAGES(SB), .FILT_LEN(FB), .STRETCH(TB)) dut_b (
        .clk(clk), .rst(rst), .din(din_b),
        .level(level_b), .rise(rise_b), .fall(fall_b), .stretch(stretch_b)
    );

    // Reference model: level flips when the last FL synchronised samples all differ from it;
    // stretch is high while fewer than STRETCH edges have passed since the latest rise.
    logic [7:0] hist   [NI][64];
    logic [7:0] m_lvl  [NI];
    logic [7:0] m_rise [NI];
    logic [7:0] m_fall [NI];
    int last_rise [NI][8];
    int nedge [NI] = '{0, 0};

    function automatic int p_w(int k);  return (k == 0) ? WA : WB;   endfunction
    function automatic int p_st(int k); return (k == 0) ? SA : SB;   endfunction
    function automatic int p_fl(int k); return (k == 0) ? FEA : FEB; endfunction
    function automatic int p_sl(int k); return (k == 0) ? TA : TB;   endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int j = 0; j < 64; j++) hist[k][j] = 8'h00;
            m_lvl[k]  = 8'h00;
            m_rise[k] = 8'h00;
            m_fall[k] = 8'h00;
            for (int c = 0; c < 8; c++) last_rise[k][c] = -1000;
        end
    endtask

    task automatic model_step(input int k, input logic [7:0] d);
        logic diff;
        logic nl;
        nedge[k]++;
        for (int j = 63; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = d;
        m_rise[k] = 8'h00;
        m_fall[k] = 8'h00;
        for (int c = 0; c < p_w(k); c++) begin
            diff = 1'b1;
            for (int j = 0; j < p_fl(k); j++) begin
                if (hist[k][p_st(k) + j][c] == m_lvl[k][c]) diff = 1'b0;
            end
            if (diff) begin
                nl = ~m_lvl[k][c];
                m_rise[k][c] = nl;
                m_fall[k][c] = ~nl;
                if (nl) last_rise[k][c] = nedge[k];
                m_lvl[k][c] = nl;
            end
        end
    endtask

    function automatic logic [7:0] m_str(int k);
        logic [7:0] r;
        r = 8'h00;
        for (int c = 0; c < p_w(k); c++) r[c] = ((nedge[k] - last_rise[k][c]) < p_sl(k));
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            model_step(0, {4'h0, din_a});
            model_step(1, din_b);
        end
    end

    // every cycle, both instances against the model
    always @(negedge clk) begin
        check("model_a", {16'h0, level_a, rise_a, fall_a, stretch_a},
              {16'h0, m_lvl[0][3:0], m_rise[0][3:0], m_fall[0][3:0], m_str(0)[3:0]});
        check("model_b", {level_b, rise_b, fall_b, stretch_b},
              {m_lvl[1], m_rise[1], m_fall[1], m_str(1)});
    end

    typedef struct {
        logic [3:0] din;
        logic [3:0] lvl;
        logic [3:0] rs;
        logic [3:0] fl;
        logic [3:0] st;
    } vec_t;

    vec_t tbl [6];

    int n_l, n_r, n_f, n_s, r_first, r_last, s_first, s_last;
    logic found;

    initial begin
        model_reset();
        din_a = 4'hF;
        din_b = 8'hFF;

        // reset held with all inputs high
        repeat (10) begin
            @(negedge clk);
            check("rst_a", {16'h0, level_a, rise_a, fall_a, stretch_a}, 32'h0);
            check("rst_b", {level_b, rise_b, fall_b, stretch_b}, 32'h0);
        end
        din_a = 4'h0;
        din_b = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // channel 0 latency, rise, stretch length, then fall
        din_a[0] = 1'b1;
        repeat (LAT_A) @(negedge clk);
        check("lat_pre_level0", {31'h0, level_a[0]}, 32'd0);
        @(negedge clk);
        check("lat_level0", {31'h0, level_a[0]}, 32'd1);
        check("lat_rise0", {31'h0, rise_a[0]}, 32'd1);
        check("lat_stretch0", {31'h0, stretch_a[0]}, 32'd1);
        @(negedge clk);
        check("rise0_one_cycle", {31'h0, rise_a[0]}, 32'd0);
        check("stretch0_c2", {31'h0, stretch_a[0]}, 32'd1);
        @(negedge clk);
        check("stretch0_c3", {31'h0, stretch_a[0]}, 32'd1);
        @(negedge clk);
        check("stretch0_end", {31'h0, stretch_a[0]}, 32'd0);
        din_a[0] = 1'b0;
        repeat (LAT_A) @(negedge clk);
        check("fall_pre_level0", {31'h0, level_a[0]}, 32'd1);
        @(negedge clk);
        check("fall0", {28'h0, level_a[0], rise_a[0], fall_a[0], stretch_a[0]}, 32'h2);
        @(negedge clk);
        check("fall0_one_cycle", {31'h0, fall_a[0]}, 32'd0);
        repeat (8) @(negedge clk);

        // two-cycle glitch on channel 1
        n_l = 0; n_r = 0; n_f = 0; n_s = 0;
        din_a[1] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 1) din_a[1] = 1'b0;
            n_l += int'(level_a[1]);
            n_r += int'(rise_a[1]);
            n_f += int'(fall_a[1]);
            n_s += int'(stretch_a[1]);
        end
`ifdef SYNC_EDGE_FILT_FILTER_EN
        check("glitch_counts", {n_l[7:0], n_r[7:0], n_f[7:0], n_s[7:0]}, 32'h00000000);
`else
        check("glitch_counts", {n_l[7:0], n_r[7:0], n_f[7:0], n_s[7:0]}, 32'h02010103);
`endif

        // retrigger on B channel 2: high 4, low 4, high
        n_r = 0; n_s = 0; r_first = -1; r_last = -1; s_first = -1; s_last = -1;
        din_b[2] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 3) din_b[2] = 1'b0;
            if (i == 7) din_b[2] = 1'b1;
            if (rise_b[2]) begin
                n_r++;
                if (r_first < 0) r_first = i;
                r_last = i;
            end
            if (stretch_b[2]) begin
                n_s++;
                if (s_first < 0) s_first = i;
                s_last = i;
            end
        end
        check("retrig_rises", n_r, 32'd2);
        check("retrig_spacing", r_last - r_first, 32'd8);
        check("retrig_stretch_len", n_s, 32'd18);
        check("retrig_no_gap", s_last - s_first + 1, 32'd18);
        din_b[2] = 1'b0;
        repeat (20) @(negedge clk);

        // asynchronous reset one cycle into a stretch on A channel 3
        din_a[3] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (rise_a[3]) found = 1'b1;
        end
        check("rise3_seen", {31'h0, found}, 32'd1);
        @(posedge clk);
        #1;
        check("stretch3_before_rst", {31'h0, stretch_a[3]}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_a", {16'h0, level_a, rise_a, fall_a, stretch_a}, 32'h0);
        check("async_rst_b", {level_b, rise_b, fall_b, stretch_b}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT_A) @(negedge clk);
        check("post_rst_pre_rise3", {30'h0, level_a[3], rise_a[3]}, 32'd0);
        @(negedge clk);
        check("post_rst_rise3", {30'h0, level_a[3], rise_a[3]}, 32'd3);
        din_a[3] = 1'b0;
        repeat (12) @(negedge clk);

        // parallel edges on B
        din_b = 8'hA5;
        repeat (LAT_B) @(negedge clk);
        check("b_pre_level", {24'h0, level_b}, 32'h0);
        @(negedge clk);
        check("b_level", {24'h0, level_b}, 32'hA5);
        check("b_rise", {24'h0, rise_b}, 32'hA5);
        check("b_fall", {24'h0, fall_b}, 32'h0);
        check("b_stretch", {24'h0, stretch_b}, 32'hA5);
        din_b = 8'h00;

        // steady-state table on A: each pattern held long enough for all pulses to expire
        tbl[0] = '{din: 4'h5, lvl: 4'h5, rs: 4'h0, fl: 4'h0, st: 4'h0};
        tbl[1] = '{din: 4'hA, lvl: 4'hA, rs: 4'h0, fl: 4'h0, st: 4'h0};
        tbl[2] = '{din: 4'hF, lvl: 4'hF, rs: 4'h0, fl: 4'h0, st: 4'h0};
        tbl[3] = '{din: 4'h0, lvl: 4'h0, rs: 4'h0, fl: 4'h0, st: 4'h0};
        tbl[4] = '{din: 4'h3, lvl: 4'h3, rs: 4'h0, fl: 4'h0, st: 4'h0};
        tbl[5] = '{din: 4'hC, lvl: 4'hC, rs: 4'h0, fl: 4'h0, st: 4'h0};
        for (int v = 0; v < 6; v++) begin
            din_a = tbl[v].din;
            repeat (12) @(negedge clk);
            check($sformatf("table_%0d", v), {16'h0, level_a, rise_a, fall_a, stretch_a},
                  {16'h0, tbl[v].lvl, tbl[v].rs, tbl[v].fl, tbl[v].st});
        end

        // randomized stimulus with bursty changes and one short mid-cycle reset
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) din_a = 4'($urandom);
            if ($urandom_range(2) == 0) din_b = din_b ^ 8'($urandom & $urandom);
            if (i == 400) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
